// File: rtl/arith_pkg.sv
// arith_pkg
// Shared definitions for the arithmetic library datapath blocks.
//   op_e          : requester opcode (OP_NEG = negate, OP_ABS = absolute value)
//   mostNegative  : two's-complement most-negative constant for a given width,
//                   returned in a 64-bit container (callers cast to their width)
package arith_pkg;

  typedef enum logic {
    OP_NEG = 1'b0,
    OP_ABS = 1'b1
  } op_e;

  // The most-negative pattern is a single set MSB; widths above 64 are not
  // used anywhere in the library.
  function automatic logic [63:0] mostNegative(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter that owns the priority pointer. The search starts at the
// pointer and wraps modulo NREQ; after an advance the pointer moves just past
// the granted requester so it gets lowest priority next time.
// Ports:
//   iClk      : clock, rising edge
//   iRst      : asynchronous active-high reset (pointer returns to 0)
//   iReq      : request vector, one bit per requester
//   iAdvance  : the current grant was taken; move the pointer
//   oGrant    : one-hot grant (zero when no request is present)
//   oGrantIdx : encoded index of the granted requester
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic [NREQ-1:0] iReq,
  input  logic            iAdvance,
  output logic [NREQ-1:0] oGrant,
  output logic [IDW-1:0]  oGrantIdx
);

  logic [IDW-1:0]    r_ptr;
  logic [2*NREQ-1:0] w_reqDouble;
  logic [IDW-1:0]    w_offset;
  logic              w_found;
  logic [IDW:0]      w_sum;
  logic [IDW-1:0]    w_idx;
  logic [IDW-1:0]    w_ptrNext;

  // Rotating the doubled request vector puts the pointer position at bit 0,
  // so a plain lowest-set-bit search yields the distance from the pointer.
  assign w_reqDouble = {iReq, iReq} >> r_ptr;

  // Find the first pending request at or after the pointer.
  always_comb begin
    w_offset = '0;
    w_found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && w_reqDouble[i]) begin
        w_found  = 1'b1;
        w_offset = IDW'(i);
      end
    end
  end

  // Pointer plus offset never exceeds 2*NREQ-2, so one conditional subtract
  // is enough to wrap it back into range for non-power-of-two NREQ.
  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_offset};
  assign w_idx     = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ))
                                               : IDW'(w_sum);
  assign w_ptrNext = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + IDW'(1);

  assign oGrant    = w_found ? (NREQ'(1) << w_idx) : '0;
  assign oGrantIdx = w_idx;

  // The pointer only moves when the downstream register actually took a grant.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_ptr <= '0;
    end else if (iAdvance && w_found) begin
      r_ptr <= w_ptrNext;
    end
  end

endmodule

// File: rtl/negate_arbiter.sv
// negate_arbiter
// Shares one two's-complement negate/absolute-value datapath among NREQ
// requesters. A round-robin arbiter picks one requester per cycle; the
// selected operand is negated (or abs'd) into a single output register that
// also carries the requester tag and an overflow flag.
// Configuration macro:
//   NEGATE_ARBITER_SATURATE_EN : when defined, negating the most-negative
//   value returns the most-positive value instead of wrapping (oOvf still set).
// Ports:
//   iClk      : clock, rising edge
//   iRst      : asynchronous active-high reset
//   iReqValid : per-requester request valid
//   iReqOp    : per-requester opcode (0 = negate, 1 = absolute value)
//   iReqData  : operands, requester k at [k*WIDTH +: WIDTH]
//   oReqReady : one-hot acceptance strobe (combinational)
//   oValid    : output register holds a result
//   iReady    : downstream takes the result this cycle
//   oData     : result
//   oId       : index of the requester that produced oData
//   oOvf      : operand was the most-negative value and was negated
module negate_arbiter
  import arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [NREQ-1:0]       iReqValid,
  input  logic [NREQ-1:0]       iReqOp,
  input  logic [NREQ*WIDTH-1:0] iReqData,
  output logic [NREQ-1:0]       oReqReady,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [WIDTH-1:0]      oData,
  output logic [IDW-1:0]        oId,
  output logic                  oOvf
);

  localparam logic [WIDTH-1:0] C_MOST_NEG = WIDTH'(mostNegative(WIDTH));
  localparam logic [WIDTH-1:0] C_MOST_POS = ~C_MOST_NEG;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [IDW-1:0]   r_id;
  logic             r_ovf;

  logic             w_accept;
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_grantIdx;
  logic [WIDTH-1:0] w_operand;
  op_e              w_op;
  logic             w_doNeg;
  logic             w_ovf;
  logic [WIDTH-1:0] w_negated;
  logic [WIDTH-1:0] w_result;

  // The output register can take a new result when empty or draining this
  // cycle, which gives back-to-back throughput.
  assign w_accept  = (!r_valid || iReady) && (|iReqValid);
  assign oReqReady = {NREQ{w_accept}} & w_grant;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .iClk      (iClk),
    .iRst      (iRst),
    .iReq      (iReqValid),
    .iAdvance  (w_accept),
    .oGrant    (w_grant),
    .oGrantIdx (w_grantIdx)
  );

  // Operand/opcode mux driven by the one-hot grant.
  always_comb begin
    w_operand = '0;
    w_op      = OP_NEG;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant[k]) begin
        w_operand = iReqData[k*WIDTH +: WIDTH];
        w_op      = op_e'(iReqOp[k]);
      end
    end
  end

  // Abs only negates negative operands; overflow is flagged only when a
  // negation of the most-negative value really happens.
  assign w_doNeg   = (w_op == OP_NEG) || w_operand[WIDTH-1];
  assign w_negated = ~w_operand + WIDTH'(1);
  assign w_ovf     = w_doNeg && (w_operand == C_MOST_NEG);

`ifdef NEGATE_ARBITER_SATURATE_EN
  // Clamp the single unrepresentable case to the most-positive value.
  assign w_result = !w_doNeg ? w_operand : (w_ovf ? C_MOST_POS : w_negated);
`else
  // Wraparound: negating the most-negative value yields itself.
  assign w_result = w_doNeg ? w_negated : w_operand;
  logic w_unusedMostPos;
  assign w_unusedMostPos = ^C_MOST_POS;
`endif

  // Output register: load on accept, clear valid when drained with nothing
  // new to take; data fields hold their last value otherwise.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_result;
      r_id    <= w_grantIdx;
      r_ovf   <= w_ovf;
    end else if (iReady) begin
      r_valid <= 1'b0;
    end
  end

  assign oValid = r_valid;
  assign oData  = r_data;
  assign oId    = r_id;
  assign oOvf   = r_ovf;

endmodule

// File: tb/tb_negate_arbiter.sv
// tb_negate_arbiter
// Self-checking bench for negate_arbiter (WIDTH=8, NREQ=4) with a
// behavioural reference model built from signed integer arithmetic.
module tb_negate_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
`ifdef NEGATE_ARBITER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                  iClk;
  logic                  iRst;
  logic [NREQ-1:0]       iReqValid;
  logic [NREQ-1:0]       iReqOp;
  logic [NREQ*WIDTH-1:0] iReqData;
  logic [NREQ-1:0]       oReqReady;
  logic                  oValid;
  logic                  iReady;
  logic [WIDTH-1:0]      oData;
  logic [IDW-1:0]        oId;
  logic                  oOvf;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model state
  bit mValid;
  int mData;
  int mId;
  bit mOvf;
  int mPtr;

  negate_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iReqValid (iReqValid),
    .iReqOp    (iReqOp),
    .iReqData  (iReqData),
    .oReqReady (oReqReady),
    .oValid    (oValid),
    .iReady    (iReady),
    .oData     (oData),
    .oId       (oId),
    .oOvf      (oOvf)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Signed view of the operand; negate or abs done in integer arithmetic.
  function automatic int signedOf(input int a);
    return (a >= (1 << (WIDTH - 1))) ? a - (1 << WIDTH) : a;
  endfunction

  function automatic bit refOvf(input int a, input bit op);
    int s = signedOf(a);
    return (s == -(1 << (WIDTH - 1))) && (op == 1'b0 || s < 0);
  endfunction

  function automatic int refResult(input int a, input bit op);
    int s = signedOf(a);
    int r;
    r = (op == 1'b0 || s < 0) ? -s : s;
    if (SAT && refOvf(a, op)) r = (1 << (WIDTH - 1)) - 1;
    return r & ((1 << WIDTH) - 1);
  endfunction

  task automatic resetModel();
    mValid = 0; mData = 0; mId = 0; mOvf = 0; mPtr = 0;
  endtask

  // Called at posedge+1: drive, check the acceptance strobe, advance the
  // model, then check the registered outputs just after the next edge.
  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0] op,
                               input logic [31:0] d, input logic rdy);
    bit accept;
    int g;
    logic [NREQ-1:0] expReady;
    iReqValid = v;
    iReqOp    = op;
    iReqData  = d;
    iReady    = rdy;
    #2;
    accept = (!mValid || rdy) && (v != 0);
    g = -1;
    for (int i = 0; i < NREQ; i++) begin
      int k = (mPtr + i) % NREQ;
      if (g < 0 && v[k]) g = k;
    end
    expReady = accept ? NREQ'(1 << g) : '0;
    checkOutput("reqReady", 32'(oReqReady), 32'(expReady));
    if (accept) begin
      int a = int'((d >> (g * WIDTH)) & ((1 << WIDTH) - 1));
      mValid = 1;
      mData  = refResult(a, op[g]);
      mOvf   = refOvf(a, op[g]);
      mId    = g;
      mPtr   = (g + 1) % NREQ;
    end else if (rdy) begin
      mValid = 0;
    end
    @(posedge iClk);
    #1;
    checkOutput("oValid", 32'(oValid), 32'(mValid));
    if (mValid) begin
      checkOutput("oData", 32'(oData), mData);
      checkOutput("oId", 32'(oId), mId);
      checkOutput("oOvf", 32'(oOvf), 32'(mOvf));
    end
  endtask

  initial begin
    iRst = 1'b1;
    iReqValid = '0; iReqOp = '0; iReqData = '0; iReady = 1'b0;
    resetModel();
    #12;
    checkOutput("rstValid", 32'(oValid), 0);
    checkOutput("rstData", 32'(oData), 0);
    checkOutput("rstId", 32'(oId), 0);
    checkOutput("rstOvf", 32'(oOvf), 0);
    iRst = 1'b0;
    @(posedge iClk);
    #1;

    $display("[TB] single request");
    applyStimulus(4'b0100, 4'b0000, 32'h0005_0000, 1'b1);
    checkOutput("singleData", 32'(oData), 32'hFB);
    checkOutput("singleId", 32'(oId), 2);

    $display("[TB] all requesters streaming");
    for (int i = 0; i < 6; i++) applyStimulus(4'hF, 4'(($urandom)), $urandom, 1'b1);

    $display("[TB] backpressure");
    for (int i = 0; i < 3; i++) applyStimulus(4'hF, 4'(($urandom)), $urandom, 1'b0);
    applyStimulus(4'hF, 4'(($urandom)), $urandom, 1'b1);

    $display("[TB] abs and overflow");
    applyStimulus(4'b0010, 4'b0010, 32'h0000_F600, 1'b1);
    checkOutput("absNeg", 32'(oData), 32'h0A);
    applyStimulus(4'b0010, 4'b0010, 32'h0000_7F00, 1'b1);
    checkOutput("absPos", 32'(oData), 32'h7F);
    applyStimulus(4'b0010, 4'b0000, 32'h0000_8000, 1'b1);
    checkOutput("negMin", 32'(oData), SAT ? 32'h7F : 32'h80);
    checkOutput("negMinOvf", 32'(oOvf), 1);
    applyStimulus(4'b0010, 4'b0000, 32'h0000_0000, 1'b1);
    checkOutput("negZero", 32'(oData), 0);

    $display("[TB] async reset mid-stream");
    applyStimulus(4'b0100, 4'b0000, 32'h0011_0000, 1'b0);
    iReqValid = '0;
    #2;
    iRst = 1'b1;
    #1;
    resetModel();
    checkOutput("asyncValid", 32'(oValid), 0);
    checkOutput("asyncData", 32'(oData), 0);
    #1;
    iRst = 1'b0;
    @(posedge iClk);
    #1;
    applyStimulus(4'b1010, 4'b0000, $urandom, 1'b1);
    checkOutput("postRstId", 32'(oId), 1);

    $display("[TB] fairness between 0 and 3");
    applyStimulus(4'b1000, 4'b0000, $urandom, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(4'b1001, 4'(($urandom)), $urandom, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 7) == 0) d[15:8] = 8'h80;
      applyStimulus(4'(($urandom)), 4'(($urandom)), d, 1'($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/negate_arbiter.md
Name: negate_arbiter

Overview:
- Shares one two's-complement negation datapath among NREQ requesters.
- Each requester presents an operand plus an opcode: negate or absolute value.
- A round-robin arbiter grants one requester per cycle. The selected operand passes through the negation logic into a single output register, which carries a requester tag and an overflow flag.
- Sits between the operand-producing units and the downstream adder/multiplier stages of the arithmetic library.

Parameters:
- WIDTH, 8, operand/result width in bits (two's complement).
- NREQ, 4, number of requesters (>= 2).
- IDW, $clog2(NREQ), width of the requester tag.

Ports:
- iClk  input  1  clock; all state updates on rising edge.
- iRst  input  1  asynchronous, active-high reset.
- iReqValid  input  NREQ  per-requester request valid.
- iReqOp  input  NREQ  per-requester opcode: 0 = negate, 1 = absolute value.
- iReqData  input  NREQ*WIDTH  operands; requester k occupies bits [k*WIDTH +: WIDTH].
- oReqReady  output  NREQ  one-hot (or zero) acceptance strobe per requester.
- oValid  output  1  result register holds a valid result.
- iReady  input  1  downstream accepts the result this cycle.
- oData  output  WIDTH  result.
- oId  output  IDW  index of the requester that produced oData.
- oOvf  output  1  operand was the most negative value (-2^(WIDTH-1)).

Behaviour:
- Reset (async, iRst=1): oValid=0, oData=0, oId=0, oOvf=0, round-robin pointer=0, so requester 0 has first priority after reset.
- A result still pending at reset is discarded. Requesters must treat their last unacknowledged request as not accepted.
- Accept condition: accept = (!oValid | iReady) & |iReqValid. The output register drains and refills in the same cycle, giving full throughput of 1 result/cycle.
- Arbitration:
  - Grant goes to the first valid requester found by searching upward from the pointer, wrapping modulo NREQ.
  - oReqReady[k] = accept & grant[k], combinational from iReqValid, oValid and iReady.
  - On accept, the pointer becomes (granted index + 1) mod NREQ. Otherwise the pointer holds.
- Datapath for operand A:
  - Negate: result = ~A + 1, truncated to WIDTH.
  - Absolute value: result = A if A[WIDTH-1]=0, otherwise ~A + 1.
  - No sign extension; all arithmetic is modulo 2^WIDTH.
- Overflow: oOvf=1 iff A == {1'b1, {(WIDTH-1){1'b0}}} and a negation actually occurs. That is every negate op, and abs ops with a negative operand. In that case the result is A (wraparound). Negating 0 gives 0 with oOvf=0.
- Latency: 1 cycle from accept to oValid=1 with the registered oData/oId/oOvf.
- Output hold: while oValid=1 and iReady=0, oData/oId/oOvf are stable and every oReqReady is 0.
- Drain: if oValid=1, iReady=1 and no request is valid, oValid goes to 0 next cycle and the data fields hold their old values.
- Requesters must hold iReqValid/iReqOp/iReqData until their oReqReady strobe. A request that drops before it is granted is simply not served, with no error.

Optional Feature:
- Macro: NEGATE_ARBITER_SATURATE_EN.
- Defined: an overflowing negation returns the most positive value {1'b0, {(WIDTH-1){1'b1}}}, and oOvf is still asserted.
- Undefined: wraparound result as above.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package arith_pkg:
  - opcode constants OP_NEG=1'b0, OP_ABS=1'b1.
  - function for the most-negative constant, parameterised by WIDTH.
- Sub-module rr_arbiter (parameter NREQ):
  - inputs iClk, iRst, request vector, advance strobe.
  - outputs one-hot grant and encoded index.
  - owns the pointer.
- The top level holds the operand mux, negation/abs/saturation logic and output register.

Test Plan:
- Reset then single request: iReqValid=4'b0100, op=NEG, data=8'h05. Expect oReqReady=4'b0100 in the same cycle; next cycle oValid=1, oData=8'hFB, oId=2, oOvf=0.
- All four valid continuously, iReady=1: grants in order 0,1,2,3,0, one per cycle, each oId matching, no bubbles.
- Backpressure: oValid=1 with iReady=0 for 3 cycles while requests are pending. Expect oReqReady=0 and oData stable; when iReady rises, a new grant occurs in that cycle.
- Abs and overflow on requester 1:
  - ABS 8'hF6 -> 8'h0A, oOvf=0.
  - ABS 8'h7F -> 8'h7F.
  - NEG 8'h80 -> 8'h80 with oOvf=1, or 8'h7F with oOvf=1 when NEGATE_ARBITER_SATURATE_EN is defined.
- Async reset mid-stream: assert iRst between clock edges while oValid=1. Expect oValid=0 immediately; after release the first grant goes to the lowest-index valid requester.
- Pointer fairness: requesters 0 and 3 valid, last grant was 3. Expect the next grant to 0, then 3, alternating.
